ipvc_release_gen: RTL and testbench

Downstream-router block that tracks occupancy of every input VC and returns VC-release pulses to the upstream router. Each `vc_release[p]` pulse tells the upstream output-VC availability updater to set one more VC free on the link feeding input port p. A VC is claimed when a head flit arrives into it. It is freed when its tail flit leaves the input buffer. The block serialises releases to at most one per port per cycle, queueing any surplus.

---
 rtl/ipvc_release_gen_if.sv | 47 ++++
 rtl/ipvc_release_gen.sv | 154 +++++++++++++++
 tb/tb_ipvc_release_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipvc_release_gen_if.sv
// ipvc_release_gen_if
//   Bundles the per-VC flit events coming from the input buffers and the
//   per-port release/status signals produced by ipvc_release_gen.
//
//   Signal semantics (no valid/ready here; every signal is a level sampled on
//   the rising clock edge, and every event bit is a single-cycle pulse):
//     head_arrive[p*NUM_VCS+v]  head flit written into VC v of input port p
//     tail_depart[p*NUM_VCS+v]  tail flit of VC v on port p left the buffer
//     vc_release[p]             one pulse = one VC freed on the link into port p
//     vc_busy[p*NUM_VCS+v]      VC currently held by a packet
//     pending_cnt[p*CNT_W +: CNT_W]  releases queued for port p, not yet issued
//     proto_err[p]              sticky protocol violation seen on port p
//
//   Modports:
//     master : flit-event source / status observer (input buffers, bench)
//     slave  : the release generator itself
interface ipvc_release_gen_if #(
    parameter int NUM_PORTS = 5,
    parameter int NUM_VCS   = 4
);
    localparam int CNT_W = $clog2(NUM_VCS + 1);

    logic [NUM_PORTS*NUM_VCS-1:0] head_arrive;
    logic [NUM_PORTS*NUM_VCS-1:0] tail_depart;
    logic [NUM_PORTS-1:0]         vc_release;
    logic [NUM_PORTS*NUM_VCS-1:0] vc_busy;
    logic [NUM_PORTS*CNT_W-1:0]   pending_cnt;
    logic [NUM_PORTS-1:0]         proto_err;

    modport master (
        output head_arrive,
        output tail_depart,
        input  vc_release,
        input  vc_busy,
        input  pending_cnt,
        input  proto_err
    );

    modport slave (
        input  head_arrive,
        input  tail_depart,
        output vc_release,
        output vc_busy,
        output pending_cnt,
        output proto_err
    );
endinterface

// File: rtl/ipvc_release_gen.sv
// ipvc_release_gen
//   Tracks occupancy of every input VC of a router and returns VC-release
//   pulses to the upstream router. A VC is claimed by its head flit and freed
//   when its tail flit leaves; each freed VC yields exactly one vc_release
//   pulse on its port. Several VCs freed in the same cycle are queued in a
//   per-port counter and issued one per cycle on consecutive cycles.
//
//   Ports:
//     clk    system clock, all state updates on posedge
//     reset  asynchronous, active-high reset (release synchronised upstream)
//     bus    ipvc_release_gen_if.slave : flit events in, release/status out
//
//   vc_busy is the per-VC FSM state itself (FREE=0 / ACTIVE=1), so it doubles
//   as the state observation port. vc_busy and pending_cnt come straight
//   from registers.
module ipvc_release_gen #(
    parameter  int NUM_PORTS = 5,
    parameter  int NUM_VCS   = 4,
    localparam int CNT_W     = $clog2(NUM_VCS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    ipvc_release_gen_if.slave       bus
);
    localparam int NV = NUM_PORTS * NUM_VCS;

    localparam logic [CNT_W:0]   DEP_ONE  = 1;
    localparam logic [CNT_W-1:0] PEND_ONE = 1;

    typedef enum logic {
        VC_FREE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_e;

    vc_state_e            state_q [NV];
    vc_state_e            state_d [NV];
    logic [CNT_W-1:0]     pend_q  [NUM_PORTS];
    logic [CNT_W-1:0]     pend_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0] rel_q, rel_d;
    logic [NUM_PORTS-1:0] err_q, err_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NV; i++) begin
                state_q[i] <= VC_FREE;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                pend_q[p] <= '0;
            end
            rel_q <= '0;
            err_q <= '0;
        end else begin
            for (int i = 0; i < NV; i++) begin
                state_q[i] <= state_d[i];
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                pend_q[p] <= pend_d[p];
            end
            rel_q <= rel_d;
            err_q <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state: per-VC FSM plus per-port release serialiser
    // ------------------------------------------------------------------
    always_comb begin
        logic [CNT_W:0] dep;
        logic [CNT_W:0] total;

        dep   = '0;
        total = '0;
        for (int i = 0; i < NV; i++) begin
            state_d[i] = state_q[i];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            pend_d[p] = pend_q[p];
        end
        rel_d = '0;
        err_d = err_q;

        for (int p = 0; p < NUM_PORTS; p++) begin
            dep = '0;
            for (int v = 0; v < NUM_VCS; v++) begin
                case (state_q[p*NUM_VCS + v])
                    VC_FREE: begin
                        if (bus.head_arrive[p*NUM_VCS + v]) begin
                            state_d[p*NUM_VCS + v] = VC_ACTIVE;
                        end
                        // A tail on a free VC is bogus, including one that
                        // coincides with the head (a flit cannot leave in its
                        // arrival cycle); it never counts as a release.
                        if (bus.tail_depart[p*NUM_VCS + v]) begin
                            err_d[p] = 1'b1;
                        end
                    end
                    VC_ACTIVE: begin
                        // A second head into a held VC poisons the cycle:
                        // the VC stays held and any same-cycle tail is dropped.
                        if (bus.head_arrive[p*NUM_VCS + v]) begin
                            err_d[p] = 1'b1;
                        end else if (bus.tail_depart[p*NUM_VCS + v]) begin
                            state_d[p*NUM_VCS + v] = VC_FREE;
                            dep = dep + DEP_ONE;
                        end
                    end
                    default: begin
                        state_d[p*NUM_VCS + v] = VC_FREE;
                    end
                endcase
            end

            // Issue one release now if anything is owed, keep the rest queued.
            // total never exceeds NUM_VCS, so dropping the top bit is safe.
            total = {1'b0, pend_q[p]} + dep;
            if (total != '0) begin
                rel_d[p]  = 1'b1;
                pend_d[p] = total[CNT_W-1:0] - PEND_ONE;
            end else begin
                pend_d[p] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NV; i++) begin : g_busy
        assign bus.vc_busy[i] = (state_q[i] == VC_ACTIVE);
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pend
        assign bus.pending_cnt[p*CNT_W +: CNT_W] = pend_q[p];
    end

    assign bus.vc_release = rel_q;
    assign bus.proto_err  = err_q;

    // ------------------------------------------------------------------
    // Invariants: only ACTIVE VCs can release, so the queue can never hold
    // NUM_VCS entries, and the VCs the upstream sees as unavailable never
    // exceed the VCs that exist.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chk
        a_pend_max : assert property (@(posedge clk) disable iff (reset)
            int'(pend_q[p]) <= NUM_VCS - 1);
        a_credit_sum : assert property (@(posedge clk) disable iff (reset)
            ($countones(bus.vc_busy[p*NUM_VCS +: NUM_VCS])
             + int'(pend_q[p]) + int'(rel_q[p])) <= NUM_VCS);
    end
endmodule

// File: tb/tb_ipvc_release_gen.sv
// tb_ipvc_release_gen
//   Drives per-VC head/tail events into ipvc_release_gen and checks, cycle by
//   cycle, the release vector plus one port's pending count and busy nibble.
//   Expected per-cycle records are queued in exp_q as the stimulus table is
//   built and popped as each cycle's outputs are sampled (#1 after posedge).
//   Record layout: {vc_release[4:0], pending[2:0] of port p, vc_busy nibble of port p}
module tb_ipvc_release_gen;
    localparam int NP  = 5;
    localparam int NVC = 4;
    localparam int CW  = 3;
    localparam int NV  = NP * NVC;
    localparam int W   = 12;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    ipvc_release_gen_if #(.NUM_PORTS(NP), .NUM_VCS(NVC)) bus ();

    ipvc_release_gen #(.NUM_PORTS(NP), .NUM_VCS(NVC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver / sampling ----------------
    task automatic drive_cycle(input logic [NV-1:0] h, input logic [NV-1:0] t);
        bus.head_arrive = h;
        bus.tail_depart = t;
        @(posedge clk);
        #1;
        bus.head_arrive = '0;
        bus.tail_depart = '0;
    endtask

    function automatic logic [W-1:0] obs(input int p);
        return {bus.vc_release, bus.pending_cnt[p*CW +: CW], bus.vc_busy[p*NVC +: NVC]};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        repeat (10) drive_cycle('0, '0);
        n_cmp++;
        if (bus.vc_busy !== '0) begin
            n_err++; $display("FAIL reset_busy got=%h exp=0", bus.vc_busy);
        end
        n_cmp++;
        if (bus.vc_release !== '0) begin
            n_err++; $display("FAIL reset_release got=%b exp=0", bus.vc_release);
        end
        n_cmp++;
        if (bus.pending_cnt !== '0) begin
            n_err++; $display("FAIL reset_pending got=%h exp=0", bus.pending_cnt);
        end
        n_cmp++;
        if (bus.proto_err !== '0) begin
            n_err++; $display("FAIL reset_proto_err got=%b exp=0", bus.proto_err);
        end
    endtask

    task automatic test_single_release();
        logic [NV-1:0] h[7];
        logic [NV-1:0] t[7];
        logic [W-1:0]  e;
        h = '{default: '0};
        t = '{default: '0};
        h[0][2] = 1'b1;
        t[4][2] = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({5'b00000, 3'd0, 4'b0100});
        exp_q.push_back({5'b00001, 3'd0, 4'b0000});
        exp_q.push_back({5'b00000, 3'd0, 4'b0000});
        exp_q.push_back({5'b00000, 3'd0, 4'b0000});
        for (int i = 0; i < 7; i++) begin
            drive_cycle(h[i], t[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs(0) !== e) begin
                n_err++; $display("FAIL single_p0 cyc%0d got=%h exp=%h", i, obs(0), e);
            end
        end
    endtask

    task automatic test_burst_drain();
        logic [NV-1:0] h[6];
        logic [NV-1:0] t[6];
        logic [W-1:0]  e;
        h = '{default: '0};
        t = '{default: '0};
        h[0][7:4] = 4'hF;
        t[1][7:4] = 4'hF;
        exp_q.push_back({5'b00000, 3'd0, 4'b1111});
        exp_q.push_back({5'b00010, 3'd3, 4'b0000});
        exp_q.push_back({5'b00010, 3'd2, 4'b0000});
        exp_q.push_back({5'b00010, 3'd1, 4'b0000});
        exp_q.push_back({5'b00010, 3'd0, 4'b0000});
        exp_q.push_back({5'b00000, 3'd0, 4'b0000});
        for (int i = 0; i < 6; i++) begin
            drive_cycle(h[i], t[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs(1) !== e) begin
                n_err++; $display("FAIL burst_p1 cyc%0d got=%h exp=%h", i, obs(1), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NV-1:0] h[5];
        logic [NV-1:0] t[5];
        logic [W-1:0]  e;
        h = '{default: '0};
        t = '{default: '0};
        h[0][14:12] = 3'b111;
        t[1][13:12] = 2'b11;
        t[2][14]    = 1'b1;
        exp_q.push_back({5'b00000, 3'd0, 4'b0111});
        exp_q.push_back({5'b01000, 3'd1, 4'b0100});
        exp_q.push_back({5'b01000, 3'd1, 4'b0000});
        exp_q.push_back({5'b01000, 3'd0, 4'b0000});
        exp_q.push_back({5'b00000, 3'd0, 4'b0000});
        for (int i = 0; i < 5; i++) begin
            drive_cycle(h[i], t[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs(3) !== e) begin
                n_err++; $display("FAIL b2b_p3 cyc%0d got=%h exp=%h", i, obs(3), e);
            end
        end
    endtask

    task automatic test_random_bursts();
        logic [NV-1:0] hv;
        logic [NV-1:0] tv;
        logic [3:0]    m;
        logic [W-1:0]  e;
        int            k;
        int            r;
        for (int it = 0; it < 4; it++) begin
            k = $urandom_range(1, 4);
            r = $urandom_range(0, 3);
            m = '0;
            for (int j = 0; j < k; j++) m[(r + j) % 4] = 1'b1;
            hv = '0;
            hv[3:0] = m;
            exp_q.push_back({5'b00000, 3'd0, m});
            for (int j = 0; j < k; j++) exp_q.push_back({5'b00001, 3'(k - 1 - j), 4'b0000});
            exp_q.push_back({5'b00000, 3'd0, 4'b0000});
            for (int c = 0; c < k + 2; c++) begin
                tv = '0;
                if (c == 1) tv[3:0] = m;
                drive_cycle(c == 0 ? hv : '0, tv);
                e = exp_q.pop_front();
                n_cmp++;
                if (obs(0) !== e) begin
                    n_err++; $display("FAIL rand_p0 it%0d k%0d cyc%0d got=%h exp=%h", it, k, c, obs(0), e);
                end
            end
            repeat ($urandom_range(0, 3)) drive_cycle('0, '0);
        end
    endtask

    task automatic test_proto_err();
        logic [NV-1:0] h[5];
        logic [NV-1:0] t[5];
        logic [W-1:0]  e;
        h = '{default: '0};
        t = '{default: '0};
        t[0][8]  = 1'b1;
        h[1][9]  = 1'b1;
        h[2][9]  = 1'b1;
        h[3][10] = 1'b1;
        t[3][10] = 1'b1;
        n_cmp++;
        if (bus.proto_err !== 5'b00000) begin
            n_err++; $display("FAIL proto_clean got=%b exp=00000", bus.proto_err);
        end
        exp_q.push_back({5'b00000, 3'd0, 4'b0000});
        exp_q.push_back({5'b00000, 3'd0, 4'b0010});
        exp_q.push_back({5'b00000, 3'd0, 4'b0010});
        exp_q.push_back({5'b00000, 3'd0, 4'b0110});
        exp_q.push_back({5'b00000, 3'd0, 4'b0110});
        for (int i = 0; i < 5; i++) begin
            drive_cycle(h[i], t[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs(2) !== e) begin
                n_err++; $display("FAIL proto_p2 cyc%0d got=%h exp=%h", i, obs(2), e);
            end
            n_cmp++;
            if (bus.proto_err !== 5'b00100) begin
                n_err++; $display("FAIL proto_flag cyc%0d got=%b exp=00100", i, bus.proto_err);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [NV-1:0] hv;
        logic [NV-1:0] tv;
        logic [W-1:0]  e;
        hv = '0;
        tv = '0;
        hv[19:16] = 4'hF;
        tv[19:16] = 4'hF;
        exp_q.push_back({5'b00000, 3'd0, 4'b1111});
        exp_q.push_back({5'b10000, 3'd3, 4'b0000});
        drive_cycle(hv, '0);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs(4) !== e) begin
            n_err++; $display("FAIL rst_fill got=%h exp=%h", obs(4), e);
        end
        drive_cycle('0, tv);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs(4) !== e) begin
            n_err++; $display("FAIL rst_drain got=%h exp=%h", obs(4), e);
        end
        // Mid-cycle asynchronous reset: everything must drop without a clock.
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs(4) !== '0) begin
            n_err++; $display("FAIL rst_async got=%h exp=000", obs(4));
        end
        n_cmp++;
        if (bus.proto_err !== '0 || bus.vc_busy !== '0) begin
            n_err++; $display("FAIL rst_async_all err=%b busy=%h exp=0", bus.proto_err, bus.vc_busy);
        end
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 6; i++) exp_q.push_back('0);
        for (int i = 0; i < 6; i++) begin
            drive_cycle('0, '0);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs(4) !== e || bus.pending_cnt !== '0) begin
                n_err++; $display("FAIL rst_stale cyc%0d got=%h pend=%h exp=%h", i, obs(4), bus.pending_cnt, e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.head_arrive = '0;
        bus.tail_depart = '0;
        test_reset();
        test_single_release();
        test_burst_drain();
        test_back_to_back();
        test_random_bursts();
        test_proto_err();
        test_reset_mid_drain();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
